// File: rtl/branch_update_queue.sv
// In-order branch update queue: fetch allocates, execute resolves by tag, ROB retires in order.
// Optional BUQ_STATS_EN adds saturating commit/mispredict counters.
module branch_update_queue #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred,
  output logic [IDX_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  input  logic             retire_valid,
  output logic             retire_ready,
  input  logic             flush,
  output logic             branch_commit,
  output logic             branch_taken,
  output logic [31:0]      branch_taken_pc,
  output logic             mispredict,
  output logic [IDX_W:0]   count
`ifdef BUQ_STATS_EN
  ,
  output logic [31:0]      stat_commits,
  output logic [31:0]      stat_mispredicts
`endif
);

  logic [DEPTH-1:0] valid_q, resolved_q, pred_q, taken_q;
  logic [31:0]      pc_q [DEPTH];
  logic [IDX_W:0]   head_q, tail_q;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, alloc_fire, resolve_fire, retire_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);

  assign alloc_ready  = !full && !flush;
  // Uses the registered resolved bit, so a same-cycle resolve cannot enable retire.
  assign retire_ready = valid_q[head_idx] && resolved_q[head_idx];
  assign alloc_tag    = tail_idx;
  assign count        = tail_q - head_q;

  assign alloc_fire   = alloc_valid && alloc_ready;
  assign resolve_fire = resolve_valid && !flush && valid_q[resolve_tag] &&
                        !resolved_q[resolve_tag];
  assign retire_fire  = retire_valid && retire_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      resolved_q <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (alloc_fire) begin
        valid_q[tail_idx]    <= 1'b1;
        resolved_q[tail_idx] <= 1'b0;
        pred_q[tail_idx]     <= alloc_pred;
        pc_q[tail_idx]       <= alloc_pc;
        tail_q               <= tail_q + 1'b1;
      end
      if (resolve_fire) begin
        resolved_q[resolve_tag] <= 1'b1;
        taken_q[resolve_tag]    <= resolve_taken;
      end
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
    end
  end

  // Update strobe reads the head slot before the flush/pop takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_commit   <= 1'b0;
      branch_taken    <= 1'b0;
      branch_taken_pc <= '0;
      mispredict      <= 1'b0;
    end else begin
      branch_commit <= retire_fire;
      mispredict    <= retire_fire && (taken_q[head_idx] != pred_q[head_idx]);
      if (retire_fire) begin
        branch_taken    <= taken_q[head_idx];
        branch_taken_pc <= pc_q[head_idx];
      end
    end
  end

`ifdef BUQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_commits     <= '0;
      stat_mispredicts <= '0;
    end else if (retire_fire) begin
      if (stat_commits != 32'hFFFF_FFFF) stat_commits <= stat_commits + 1'b1;
      if ((taken_q[head_idx] != pred_q[head_idx]) && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized bench for branch_update_queue against a queue-based reference model.
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid, alloc_pred, resolve_valid, resolve_taken, retire_valid, flush;
  logic [31:0]      alloc_pc;
  logic [IDX_W-1:0] resolve_tag, alloc_tag;
  logic             alloc_ready, retire_ready, branch_commit, branch_taken, mispredict;
  logic [31:0]      branch_taken_pc;
  logic [IDX_W:0]   count;
`ifdef BUQ_STATS_EN
  logic [31:0]      stat_commits, stat_mispredicts;
`endif

  branch_update_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_pc        (alloc_pc),
    .alloc_pred      (alloc_pred),
    .alloc_tag       (alloc_tag),
    .resolve_valid   (resolve_valid),
    .resolve_tag     (resolve_tag),
    .resolve_taken   (resolve_taken),
    .retire_valid    (retire_valid),
    .retire_ready    (retire_ready),
    .flush           (flush),
    .branch_commit   (branch_commit),
    .branch_taken    (branch_taken),
    .branch_taken_pc (branch_taken_pc),
    .mispredict      (mispredict),
    .count           (count)
`ifdef BUQ_STATS_EN
    ,
    .stat_commits    (stat_commits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        resolved;
    logic        taken;
    int          tag;
  } ent_t;

  ent_t        q[$];
  int          next_tag;
  logic        exp_commit, exp_taken, exp_mis;
  logic [31:0] exp_pc;
  logic [31:0] exp_commits, exp_mispredicts;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    next_tag        = 0;
    exp_commit      = 1'b0;
    exp_taken       = 1'b0;
    exp_mis         = 1'b0;
    exp_pc          = '0;
    exp_commits     = '0;
    exp_mispredicts = '0;
  endtask

  task automatic drive_idle();
    alloc_valid = 0; alloc_pc = '0; alloc_pred = 0; resolve_valid = 0; resolve_tag = '0;
    resolve_taken = 0; retire_valid = 0; flush = 0;
  endtask

  task automatic check_regs();
    check_eq("branch_commit", branch_commit, exp_commit);
    check_eq("mispredict", mispredict, exp_mis);
    if (exp_commit) begin
      check_eq("branch_taken", branch_taken, exp_taken);
      check_eq("branch_taken_pc", branch_taken_pc, exp_pc);
    end
    check_eq("count", count, q.size());
    check_eq("alloc_tag", alloc_tag, next_tag);
`ifdef BUQ_STATS_EN
    check_eq("stat_commits", stat_commits, exp_commits);
    check_eq("stat_mispredicts", stat_mispredicts, exp_mispredicts);
`endif
  endtask

  // One clock cycle: check registered state, drive inputs, check handshakes, advance model.
  task automatic step(input logic av, input logic [31:0] pc, input logic pd, input logic rv,
                      input logic [IDX_W-1:0] rt, input logic rtk, input logic retv,
                      input logic fl);
    bit ar, rr, rfire;
    @(negedge clk);
    check_regs();
    alloc_valid = av; alloc_pc = pc; alloc_pred = pd; resolve_valid = rv; resolve_tag = rt;
    resolve_taken = rtk; retire_valid = retv; flush = fl;
    ar = (q.size() < DEPTH) && !fl;
    rr = (q.size() > 0) && q[0].resolved;
    #1;
    check_eq("alloc_ready", alloc_ready, ar);
    check_eq("retire_ready", retire_ready, rr);
    rfire = retv && rr;
    exp_commit = rfire;
    exp_mis    = rfire && (q[0].taken != q[0].pred);
    if (rfire) begin
      exp_taken = q[0].taken;
      exp_pc    = q[0].pc;
      if (exp_commits != 32'hFFFF_FFFF) exp_commits++;
      if (exp_mis && exp_mispredicts != 32'hFFFF_FFFF) exp_mispredicts++;
    end
    if (fl) begin
      q.delete();
      next_tag = 0;
    end else begin
      if (rv) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(rt) && !q[i].resolved) begin
            q[i].resolved = 1'b1;
            q[i].taken    = rtk;
          end
        end
      end
      if (rfire) void'(q.pop_front());
      if (av && ar) begin
        q.push_back('{pc: pc, pred: pd, resolved: 1'b0, taken: 1'b0, tag: next_tag});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic pd);
    step(1, pc, pd, 0, '0, 0, 0, 0);
  endtask
  task automatic do_resolve(input logic [IDX_W-1:0] t, input logic tk);
    step(0, '0, 0, 1, t, tk, 0, 0);
  endtask
  task automatic do_retire();
    step(0, '0, 0, 0, '0, 0, 1, 0);
  endtask
  task automatic do_flush();
    step(0, '0, 0, 0, '0, 0, 0, 1);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_branch_commit", branch_commit, 0);
    check_eq("rst_branch_taken", branch_taken, 0);
    check_eq("rst_branch_taken_pc", branch_taken_pc, 0);
    check_eq("rst_mispredict", mispredict, 0);
    check_eq("rst_retire_ready", retire_ready, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_alloc_tag", alloc_tag, 0);
    check_eq("rst_alloc_ready", alloc_ready, 1);
  endtask

  initial begin
    logic [IDX_W-1:0] rt;
    drive_idle();
    model_clear();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // Basic mispredicted commit.
    do_alloc(32'h100, 1);
    do_resolve(0, 0);
    do_retire();
    #1;
    check_eq("t1_commit", branch_commit, 1);
    check_eq("t1_pc", branch_taken_pc, 32'h100);
    check_eq("t1_taken", branch_taken, 0);
    check_eq("t1_mispredict", mispredict, 1);
    check_eq("t1_count", count, 0);

    // Fill, refused 9th, wrap-around.
    do_flush();
    for (int i = 0; i < DEPTH; i++) do_alloc(32'h200 + 4 * i, i[0]);
    do_alloc(32'hDEAD, 1);
    #1;
    check_eq("t2_full_count", count, DEPTH);
    check_eq("t2_full_ready", alloc_ready, 0);
    do_resolve(0, 1);
    do_retire();
    do_alloc(32'h300, 0);
    #1;
    check_eq("t2_wrap_count", count, DEPTH);

    // Out-of-order resolve, in-order retire.
    do_flush();
    for (int i = 0; i < 3; i++) do_alloc(32'h400 + 4 * i, 1);
    do_resolve(2, 1);
    do_retire();
    do_resolve(1, 0);
    do_retire();
    do_resolve(0, 1);
    for (int i = 0; i < 3; i++) begin
      do_retire();
      #1;
      check_eq("t3_order_pc", branch_taken_pc, 32'h400 + 4 * i);
    end

    // Same-cycle resolve and retire of the head.
    do_flush();
    do_alloc(32'h500, 0);
    step(0, '0, 0, 1, '0, 0, 1, 0);
    #1;
    check_eq("t4_no_strobe", branch_commit, 0);
    do_retire();
    #1;
    check_eq("t4_strobe", branch_commit, 1);

    // Flush together with retire of a resolved head.
    do_flush();
    for (int i = 0; i < 4; i++) do_alloc(32'h600 + 4 * i, 0);
    do_resolve(0, 1);
    step(0, '0, 0, 0, '0, 0, 1, 1);
    #1;
    check_eq("t5_strobe", branch_commit, 1);
    check_eq("t5_pc", branch_taken_pc, 32'h600);
    check_eq("t5_count", count, 0);
    check_eq("t5_tag", alloc_tag, 0);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        #1;
        model_clear();
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
      end
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        rt = IDX_W'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        rt = IDX_W'($urandom_range(0, DEPTH - 1));
      step($urandom_range(0, 9) < 6, $urandom(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 6, rt, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    check_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

In-order queue between fetch/execute and the gselect predictor's training port. Fetch allocates one entry per predicted conditional branch, recording PC and predicted direction. Execute resolves entries out of order by tag. The ROB retires them in program order, and each retirement produces a registered one-cycle update pulse (branch_commit / branch_taken / branch_taken_pc) for the predictor, plus a mispredict flag.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2; IDX_W = $clog2(DEPTH)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- alloc_valid  in  1  fetch requests an entry this cycle
- alloc_ready  out  1  entry available: !full && !flush
- alloc_pc  in  32  branch PC
- alloc_pred  in  1  predicted direction (1 = taken)
- alloc_tag  out  IDX_W  slot the current alloc is written to; equals tail index
- resolve_valid  in  1  execute reports an outcome
- resolve_tag  in  IDX_W  slot being resolved
- resolve_taken  in  1  actual direction
- retire_valid  in  1  ROB retires the oldest branch this cycle
- retire_ready  out  1  head entry is valid and resolved
- flush  in  1  discard all non-retiring entries
- branch_commit  out  1  registered predictor-update strobe
- branch_taken  out  1  resolved direction of the committed entry
- branch_taken_pc  out  32  PC of the committed entry
- mispredict  out  1  asserted with branch_commit when taken != pred
- count  out  IDX_W+1  occupied entries

## Operation
- Storage per slot: valid, resolved, pred, taken, pc[31:0]. head and tail are IDX_W+1-bit pointers. Slot index = pointer[IDX_W-1:0]. full = MSBs differ and the low bits are equal. empty = head == tail.
- Alloc fires when alloc_valid && alloc_ready. The slot at tail gets valid=1, resolved=0, pc, and pred. tail increments and wraps naturally.
- Resolve fires when resolve_valid and the slot is valid and unresolved. It sets resolved=1 and taken=resolve_taken. A resolve to an invalid slot or an already-resolved slot is ignored; the first outcome sticks.
- Retire fires when retire_valid && retire_ready. It clears the head slot's valid bit and increments head. On the next edge it loads branch_commit=1, branch_taken=taken, branch_taken_pc=pc, and mispredict=(taken!=pred).
- retire_valid while retire_ready=0 is ignored: no pop and no strobe.
- Same-cycle alloc and retire are both permitted. When full, alloc is still refused that cycle; alloc_ready does not bypass on a retire.
- flush clears every valid bit and sets head=tail=0. A retire firing in the same cycle still produces its update strobe. Alloc and resolve in a flush cycle are dropped.
- Resolve and retire targeting the same head slot in one cycle: retire_ready is computed from the registered resolved bit, so retire cannot fire. retire_ready rises the next cycle.
- count = tail - head, computed modulo 2^(IDX_W+1).

## Timing
- Reset values: branch_commit=0, branch_taken=0, branch_taken_pc=0, mispredict=0, retire_ready=0, count=0, alloc_tag=0, alloc_ready=1 (when flush=0).
- The entire array and both pointers clear asynchronously on rst. Reset mid-operation drops all entries and any pending strobe.
- Alloc at edge N: entry visible at N+1 and count updates at N+1.
- Resolve at N: retire_ready can be high from N+1.
- Retire handshake in cycle N: branch_commit is high for exactly cycle N+1. Back-to-back retires produce back-to-back strobes.
- alloc_ready and retire_ready are combinational from registered state plus flush. There is no other input-to-output combinational path.

## Configuration
- BUQ_STATS_EN defined: adds outputs stat_commits[31:0] and stat_mispredicts[31:0].
  - stat_commits increments on each update strobe; stat_mispredicts increments on each strobe with mispredict=1.
  - Both saturate at 32'hFFFF_FFFF, clear on rst, and are unaffected by flush.
- BUQ_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then alloc pc=0x100 pred=1, resolve tag 0 taken=0, retire → next cycle: branch_commit=1, branch_taken_pc=0x100, branch_taken=0, mispredict=1; count returns to 0.
- Alloc 8 entries (DEPTH=8) → alloc_ready=0, count=8. A 9th alloc_valid is ignored. Retire one, then alloc → accepted at tag 0 (wrap-around).
- Alloc tags 0,1,2; resolve in order 2,0,1 → retire_ready stays 0 until tag 0 resolves. Three retires produce strobes in PC order 0,1,2.
- Resolve head tag in the same cycle as retire_valid → no strobe that cycle. retire_ready=1 next cycle, and retire then strobes once.
- Four entries with head resolved; assert retire_valid and flush together → one strobe for the head, count=0, alloc_tag=0 afterwards.
- With BUQ_STATS_EN: 5 retires, 2 of them mispredicted → stat_commits=5, stat_mispredicts=2. A flush leaves both unchanged.
